// File: rtl/is_uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-period helpers
// and the frame parity helper used by both the TX and RX paths.
package is_uart_pkg;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Plain-vector copies of the state codes for the state register
    localparam logic [2:0] ST_IDLE   = 3'(IDLE);
    localparam logic [2:0] ST_START  = 3'(START);
    localparam logic [2:0] ST_DATA   = 3'(DATA);
    localparam logic [2:0] ST_PARITY = 3'(PARITY);
    localparam logic [2:0] ST_STOP   = 3'(STOP);

    localparam int unsigned DEF_CLK_FREQ_HZ = 32'd50_000_000;
    localparam int unsigned DEF_BAUD_RATE   = 32'd115_200;

    // Clock cycles per serial bit, truncated
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Width of a counter that runs 0..cpb-1 (never narrower than one bit)
    function automatic int unsigned cnt_width(input int unsigned cpb);
        return (cpb > 32'd1) ? $clog2(cpb) : 32'd1;
    endfunction

    localparam int unsigned DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ_HZ, DEF_BAUD_RATE);
    localparam int unsigned DEF_CNT_W        = cnt_width(DEF_CLKS_PER_BIT);

    // Frame parity over up to 9 data bits; zero padding does not change it
    function automatic logic frame_parity(input logic [8:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/is_uart_tx_if.sv
// Host-side handshake bundle of the UART transmitter.
//   tx_data_i/tx_valid_i : byte offered by the host
//   tx_ready_o           : transmitter idle, byte will be taken
//   uart_txd_o           : serial line (idle high)
//   tx_busy_o            : frame in progress
//   tx_done_o            : one-cycle pulse at end of frame
// master = host side, slave = transmitter side.
interface is_uart_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic              uart_txd_o;
    logic              tx_busy_o;
    logic              tx_done_o;

    modport master (
        output tx_data_i,
        output tx_valid_i,
        input  tx_ready_o,
        input  uart_txd_o,
        input  tx_busy_o,
        input  tx_done_o
    );

    modport slave (
        input  tx_data_i,
        input  tx_valid_i,
        output tx_ready_o,
        output uart_txd_o,
        output tx_busy_o,
        output tx_done_o
    );
endinterface

// File: rtl/is_uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
//   clk_i, rstn_i : clock, async active-low reset
//   clear         : restart the period (asserted on frame accept)
//   enable        : count while a frame is in progress
//   bit_tick      : registered, high on the last cycle of each bit period
module is_uart_baud_gen
    import is_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = cnt_width(CLKS_PER_BIT)
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 32'd2);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Period counter; tick_r is precomputed so it is high exactly while cnt_r is at its last value
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r  <= '0;
                tick_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1);
                tick_r <= (cnt_r == CNT_PRE_LAST);
            end
        end else begin
            cnt_r  <= cnt_r;
            tick_r <= 1'b0;
        end
    end

    assign bit_tick = tick_r;

endmodule

// File: rtl/is_uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks; all outputs are flops.
//   clk_i  : system clock
//   rstn_i : async active-low reset; an abandoned frame is not resumed
//   bus    : slave side of is_uart_tx_if (data/valid in; ready, txd, busy, done out)
module is_uart_tx
    import is_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    is_uart_tx_if.slave  bus
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [3:0]  LAST_BIT     = 4'(DATA_W - 32'd1);
    localparam logic        LAST_STOP    = 1'(STOP_BITS - 32'd1);
    localparam logic        PAR_ODD      = (PARITY_ODD != 32'd0);
    localparam logic        PAR_EN       = (PARITY_EN != 32'd0);

    logic [2:0]        state_r;
    logic [DATA_W-1:0] shift_r;
    logic [3:0]        bit_idx_r;
    logic              stop_idx_r;
    logic              parity_r;
    logic              txd_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              accept_s;
    logic              tick_s;

    assign accept_s = (state_r == ST_IDLE) && ready_r && bus.tx_valid_i;

    is_uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear    (accept_s),
        .enable   (busy_r),
        .bit_tick (tick_s)
    );

    // Frame sequencer; txd_r is loaded with the level of the bit that starts at each transition
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            bit_idx_r  <= '0;
            stop_idx_r <= 1'b0;
            parity_r   <= 1'b0;
            txd_r      <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r   <= bus.tx_data_i;
                        parity_r  <= frame_parity(9'(bus.tx_data_i), PAR_ODD);
                        bit_idx_r <= '0;
                        state_r   <= ST_START;
                        txd_r     <= 1'b0;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        txd_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= '0;
                        txd_r     <= shift_r[0];
                    end else begin
                        txd_r <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == LAST_BIT) begin
                            if (PAR_EN) begin
                                state_r <= ST_PARITY;
                                txd_r   <= parity_r;
                            end else begin
                                state_r    <= ST_STOP;
                                stop_idx_r <= 1'b0;
                                txd_r      <= 1'b1;
                            end
                        end else begin
                            // Next bit is shift_r[1] before the shift takes effect
                            bit_idx_r <= bit_idx_r + 4'd1;
                            shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        txd_r <= shift_r[0];
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        state_r    <= ST_STOP;
                        stop_idx_r <= 1'b0;
                        txd_r      <= 1'b1;
                    end else begin
                        txd_r <= parity_r;
                    end
                end
                ST_STOP: begin
                    txd_r <= 1'b1;
                    if (tick_s) begin
                        if (stop_idx_r == LAST_STOP) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                        end
                    end else begin
                        stop_idx_r <= stop_idx_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd_r   <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uart_txd_o = txd_r;
    assign bus.tx_ready_o = ready_r;
    assign bus.tx_busy_o  = busy_r;
    assign bus.tx_done_o  = done_r;

endmodule

// File: tb/tb_is_uart_tx.sv
// Self-checking bench for is_uart_tx: four instances (8N1, even parity,
// odd parity, two stop bits) at 10 clocks per bit.
module tb_is_uart_tx;
    import is_uart_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 10;
    localparam int NDUT   = 4;

    logic            clk;
    logic            rstn;
    logic [7:0]      data_s [NDUT];
    logic [NDUT-1:0] valid_s;
    logic [NDUT-1:0] txd_s;
    logic [NDUT-1:0] ready_s;
    logic [NDUT-1:0] busy_s;
    logic [NDUT-1:0] done_s;

    int errors = 0;
    int checks = 0;

    // Per-frame observations used by the directed checks
    int   last_done_at;
    logic last_par;
    int   high_run;
    int   last_gap;

    typedef struct {
        logic txd;
        logic ready;
        logic done;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int         d;
        logic [7:0] data;
        int         exp_done;
        logic       exp_par;
    } vec_t;
    vec_t vecs [8];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int PEN  = (g == 1 || g == 2) ? 1 : 0;
        localparam int PODD = (g == 2) ? 1 : 0;
        localparam int SB   = (g == 3) ? 2 : 1;
        is_uart_tx_if #(.DATA_W(8)) bus ();
        assign bus.tx_data_i  = data_s[g];
        assign bus.tx_valid_i = valid_s[g];
        assign txd_s[g]       = bus.uart_txd_o;
        assign ready_s[g]     = bus.tx_ready_o;
        assign busy_s[g]      = bus.tx_busy_o;
        assign done_s[g]      = bus.tx_done_o;
        is_uart_tx #(
            .CLK_FREQ_HZ (CLK_HZ),
            .BAUD_RATE   (BAUD),
            .DATA_W      (8),
            .PARITY_EN   (PEN),
            .PARITY_ODD  (PODD),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk_i  (clk),
            .rstn_i (rstn),
            .bus    (bus)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int pen(input int d);
        return (d == 1 || d == 2) ? 1 : 0;
    endfunction
    function automatic logic podd(input int d);
        return (d == 2);
    endfunction
    function automatic int sb(input int d);
        return (d == 3) ? 2 : 1;
    endfunction
    function automatic int frame_cycles(input int d);
        return (1 + 8 + pen(d) + sb(d)) * CPB;
    endfunction

    // Reference line level in cycle c (1 = first cycle after the accept edge)
    function automatic logic exp_txd(input int d, input logic [7:0] b, input int c);
        int bn;
        bn = (c - 1) / CPB;
        if (bn == 0) return 1'b0;
        if (bn <= 8) return b[bn-1];
        if (pen(d) == 1 && bn == 9) return podd(d) ? ~(^b) : (^b);
        return 1'b1;
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Offer a byte on instance d; it is accepted at the next rising edge
    task automatic start_frame(input int d, input logic [7:0] b);
        @(negedge clk);
        check_bit($sformatf("d%0d_ready_before_accept", d), ready_s[d], 1'b1);
        data_s[d]  = b;
        valid_s[d] = 1'b1;
    endtask

    // Push the expected frame, then watch it cycle by cycle through done.
    // mode 0: drop valid after accept; 1: keep valid high, change data to 0xFF;
    // mode 2: drop valid, then poke 0xFF with valid during cycles 30..59.
    task automatic capture_frame(input int d, input logic [7:0] b, input int mode);
        int   n;
        int   bad_txd;
        int   bad_rdy;
        int   bad_busy;
        int   bad_done;
        int   first_bad;
        exp_t e;
        n         = frame_cycles(d) + 1;
        bad_txd   = 0;
        bad_rdy   = 0;
        bad_busy  = 0;
        bad_done  = 0;
        first_bad = -1;
        last_done_at = -1;
        for (int c = 1; c <= n; c++) begin
            e.txd   = exp_txd(d, b, c);
            e.ready = (c == n);
            e.done  = (c == n);
            exp_q.push_back(e);
        end
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (txd_s[d] !== e.txd) begin
                bad_txd++;
                if (first_bad < 0) first_bad = c;
            end
            if (ready_s[d] !== e.ready) bad_rdy++;
            if (busy_s[d] !== ~e.ready) bad_busy++;
            if (done_s[d] !== e.done) bad_done++;
            if (done_s[d] === 1'b1 && last_done_at < 0) last_done_at = c;
            if (c == 9 * CPB + 1) last_par = txd_s[d];
            if (txd_s[d] === 1'b1) begin
                high_run++;
            end else begin
                if (high_run > 0) last_gap = high_run;
                high_run = 0;
            end
            if (c == 1) begin
                if (mode == 1) data_s[d] = 8'hFF;
                else valid_s[d] = 1'b0;
            end
            if (mode == 2 && c == 30) begin
                data_s[d]  = 8'hFF;
                valid_s[d] = 1'b1;
            end
            if (mode == 2 && c == 60) valid_s[d] = 1'b0;
        end
        check_int($sformatf("d%0d_%02h_txd_bad_cycles(first=%0d)", d, b, first_bad), bad_txd, 0);
        check_int($sformatf("d%0d_%02h_ready_bad_cycles", d, b), bad_rdy, 0);
        check_int($sformatf("d%0d_%02h_busy_bad_cycles", d, b), bad_busy, 0);
        check_int($sformatf("d%0d_%02h_done_bad_cycles", d, b), bad_done, 0);
    endtask

    initial begin
        int done_cnt;
        int low_cnt;

        vecs[0] = '{0, 8'h3C, 101, 1'b0};
        vecs[1] = '{0, 8'hA5, 101, 1'b0};
        vecs[2] = '{1, 8'h07, 111, 1'b1};
        vecs[3] = '{2, 8'h07, 111, 1'b0};
        vecs[4] = '{3, 8'h55, 111, 1'b0};
        vecs[5] = '{1, 8'hE1, 111, 1'b0};
        vecs[6] = '{2, 8'h81, 111, 1'b1};
        vecs[7] = '{3, 8'hA5, 111, 1'b0};

        for (int i = 0; i < NDUT; i++) data_s[i] = 8'h00;
        valid_s  = '0;
        high_run = 0;
        last_gap = 0;
        last_par = 1'b0;
        rstn     = 1'b1;
        #2 rstn  = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check_bit($sformatf("d%0d_reset_txd", i), txd_s[i], 1'b1);
            check_bit($sformatf("d%0d_reset_ready", i), ready_s[i], 1'b1);
            check_bit($sformatf("d%0d_reset_busy", i), busy_s[i], 1'b0);
            check_bit($sformatf("d%0d_reset_done", i), done_s[i], 1'b0);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Reset in the middle of data bit 3 (0x96 has bit 3 = 0)
        start_frame(0, 8'h96);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) valid_s[0] = 1'b0;
        end
        check_bit("midframe_txd_bit3", txd_s[0], 1'b0);
        #1 rstn = 1'b0;
        #1;
        check_bit("midreset_txd", txd_s[0], 1'b1);
        check_bit("midreset_ready", ready_s[0], 1'b1);
        check_bit("midreset_busy", busy_s[0], 1'b0);
        check_bit("midreset_done", done_s[0], 1'b0);
        done_cnt = 0;
        low_cnt  = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (c == 3) rstn = 1'b1;
            if (done_s[0] !== 1'b0) done_cnt++;
            if (txd_s[0] !== 1'b1) low_cnt++;
        end
        check_int("after_reset_done_pulses", done_cnt, 0);
        check_int("after_reset_txd_low_cycles", low_cnt, 0);

        // Table-driven frames on all configurations
        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].d, vecs[i].data);
            capture_frame(vecs[i].d, vecs[i].data, 0);
            check_int($sformatf("vec%0d_done_cycle", i), last_done_at, vecs[i].exp_done);
            if (pen(vecs[i].d) == 1)
                check_bit($sformatf("vec%0d_parity_bit", i), last_par, vecs[i].exp_par);
        end

        // Back-to-back: valid held high, 0x00 then 0xFF
        high_run = 0;
        last_gap = 0;
        start_frame(0, 8'h00);
        capture_frame(0, 8'h00, 1);
        capture_frame(0, 8'hFF, 0);
        check_int("b2b_line_high_gap", last_gap, 11);
        check_int("b2b_second_done_cycle", last_done_at, 101);

        // Valid with new data while busy is ignored
        start_frame(0, 8'h5A);
        capture_frame(0, 8'h5A, 2);
        check_int("busy_poke_done_cycle", last_done_at, 101);
        @(negedge clk);
        check_bit("busy_poke_not_queued_txd", txd_s[0], 1'b1);
        check_bit("busy_poke_not_queued_ready", ready_s[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
